// File: rtl/pad_check.sv
// pad_check: reads one padded message block out of shared memory, recovers
// the message byte length from the trailing bit-length word and checks the
// padding (0x80 marker followed by zero fill up to the length word).
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   start        level request; hold high until finish, drop to release
//   memAddrLine  read address, driven only while busy, otherwise high-Z
//   memDataLine  read data; this block only listens and never drives it
//   dataLen      recovered message length in bytes (0 on error)
//   finish       check complete, dataLen/error/errCode valid
//   error        padding malformed
//   errCode      0 ok, 1 bad length word, 2 bad marker, 3 nonzero fill
//
// Build option: PAD_FILL_CHECK_EN
//   defined   - every fill byte between marker and length word is read and
//               checked (errCode 3 possible)
//   undefined - only the marker byte is read; ok latency is a fixed 5 cycles

module pad_check #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int BLOCK_SIZE = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] memAddrLine,
    inout  wire  [DATA_WIDTH-1:0] memDataLine,
    output logic [DATA_WIDTH-1:0] dataLen,
    output logic                  finish,
    output logic                  error,
    output logic [1:0]            errCode
);

    // Length/address comparisons carry one spare bit so len+offset never wraps.
    localparam int XW = DATA_WIDTH + 1;
    localparam logic [XW-1:0] LEN_ADDR  = XW'(BLOCK_SIZE - 1);
    localparam logic [XW-1:0] LAST_FILL = XW'(BLOCK_SIZE - 2);

    typedef enum logic [2:0] {S_IDLE, S_RD_LEN, S_CHK_LEN, S_SCAN, S_DONE} state_t;

    state_t                  r_state, w_stateNx;
    logic [ADDR_WIDTH-1:0]   r_addr, w_addrNx;
    logic [DATA_WIDTH-1:0]   r_len, w_lenNx;
    logic                    r_finish, w_finNx;
    logic                    r_error, w_errNx;
    logic [1:0]              r_errCode, w_codeNx;
    logic [DATA_WIDTH-1:0]   r_dataLen, w_dlNx;
`ifdef PAD_FILL_CHECK_EN
    // r_vld: a byte issued last cycle is on the data lines now, at r_cmpAddr.
    logic                    r_vld, w_vldNx;
    logic [ADDR_WIDTH-1:0]   r_cmpAddr, w_cmpNx;
    logic                    w_isMarker, w_isLast;
`else
    // Marker-only mode holds address len and compares on the third SCAN cycle.
    logic [1:0]              r_scanCnt, w_scanCntNx;
`endif

    logic [DATA_WIDTH-1:0]   w_word;
    logic [DATA_WIDTH-1:0]   w_lenNew;
    logic                    w_busy;

    assign w_word   = memDataLine;
    assign w_lenNew = w_word >> 3;
    assign w_busy   = (r_state == S_RD_LEN) || (r_state == S_CHK_LEN) || (r_state == S_SCAN);

    assign memAddrLine = w_busy ? r_addr : {ADDR_WIDTH{1'bz}};
    assign dataLen     = r_dataLen;
    assign finish      = r_finish;
    assign error       = r_error;
    assign errCode     = r_errCode;

`ifdef PAD_FILL_CHECK_EN
    assign w_isMarker = (XW'(r_cmpAddr) == {1'b0, r_len});
    assign w_isLast   = (XW'(r_cmpAddr) == LAST_FILL);
`endif

    always_comb begin
        w_stateNx = r_state;
        w_addrNx  = r_addr;
        w_lenNx   = r_len;
        w_finNx   = r_finish;
        w_errNx   = r_error;
        w_codeNx  = r_errCode;
        w_dlNx    = r_dataLen;
`ifdef PAD_FILL_CHECK_EN
        w_vldNx   = 1'b0;
        w_cmpNx   = r_addr;
`else
        w_scanCntNx = r_scanCnt;
`endif
        case (r_state)
            S_IDLE: begin
                w_finNx  = 1'b0;
                w_errNx  = 1'b0;
                w_codeNx = 2'd0;
                w_dlNx   = '0;
                if (start) begin
                    w_stateNx = S_RD_LEN;
                    w_addrNx  = LEN_ADDR[ADDR_WIDTH-1:0];
                end
            end
            S_RD_LEN: w_stateNx = start ? S_CHK_LEN : S_IDLE;
            S_CHK_LEN: begin
                if (!start) begin
                    w_stateNx = S_IDLE;
                end else begin
                    w_lenNx = w_lenNew;
                    if ((w_word[2:0] != 3'd0) || ({1'b0, w_lenNew} > LEN_ADDR)) begin
                        w_stateNx = S_DONE;
                        w_finNx   = 1'b1;
                        w_errNx   = 1'b1;
                        w_codeNx  = 2'd1;
                        w_dlNx    = '0;
                    end else if ({1'b0, w_lenNew} == LEN_ADDR) begin
                        // Message fills the block: no marker or fill to check.
                        w_stateNx = S_DONE;
                        w_finNx   = 1'b1;
                        w_dlNx    = w_lenNew;
                    end else begin
                        w_stateNx = S_SCAN;
                        w_addrNx  = w_lenNew[ADDR_WIDTH-1:0];
`ifndef PAD_FILL_CHECK_EN
                        w_scanCntNx = 2'd0;
`endif
                    end
                end
            end
            S_SCAN: begin
                if (!start) begin
                    w_stateNx = S_IDLE;
                end else begin
`ifdef PAD_FILL_CHECK_EN
                    // Issue the next address every cycle; compare what came back.
                    w_vldNx  = 1'b1;
                    w_addrNx = r_addr + 1'b1;
                    if (r_vld) begin
                        if (w_word[7:0] != (w_isMarker ? 8'h80 : 8'h00)) begin
                            w_stateNx = S_DONE;
                            w_finNx   = 1'b1;
                            w_errNx   = 1'b1;
                            w_codeNx  = w_isMarker ? 2'd2 : 2'd3;
                            w_dlNx    = '0;
                        end else if (w_isLast) begin
                            w_stateNx = S_DONE;
                            w_finNx   = 1'b1;
                            w_dlNx    = r_len;
                        end
                    end
`else
                    w_scanCntNx = r_scanCnt + 2'd1;
                    if (r_scanCnt == 2'd2) begin
                        w_stateNx = S_DONE;
                        w_finNx   = 1'b1;
                        if (w_word[7:0] != 8'h80) begin
                            w_errNx  = 1'b1;
                            w_codeNx = 2'd2;
                            w_dlNx   = '0;
                        end else begin
                            w_dlNx   = r_len;
                        end
                    end
`endif
                end
            end
            S_DONE: begin
                // Results held while start stays high; no re-run until start drops.
                if (!start) begin
                    w_stateNx = S_IDLE;
                    w_finNx   = 1'b0;
                    w_errNx   = 1'b0;
                    w_codeNx  = 2'd0;
                    w_dlNx    = '0;
                end
            end
            default: w_stateNx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_len     <= '0;
            r_finish  <= 1'b0;
            r_error   <= 1'b0;
            r_errCode <= 2'd0;
            r_dataLen <= '0;
`ifdef PAD_FILL_CHECK_EN
            r_vld     <= 1'b0;
            r_cmpAddr <= '0;
`else
            r_scanCnt <= 2'd0;
`endif
        end else begin
            r_state   <= w_stateNx;
            r_addr    <= w_addrNx;
            r_len     <= w_lenNx;
            r_finish  <= w_finNx;
            r_error   <= w_errNx;
            r_errCode <= w_codeNx;
            r_dataLen <= w_dlNx;
`ifdef PAD_FILL_CHECK_EN
            r_vld     <= w_vldNx;
            r_cmpAddr <= w_cmpNx;
`else
            r_scanCnt <= w_scanCntNx;
`endif
        end
    end

endmodule

// File: tb/tb_pad_check.sv
module tb_pad_check;
    localparam int DW = 16;
    localparam int AW = 10;
    localparam int BS = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    wire  [AW-1:0] memAddrLine;
    wire  [DW-1:0] memDataLine;
    logic [DW-1:0] dataLen;
    logic          finish;
    logic          error;
    logic [1:0]    errCode;

    logic [DW-1:0] mem [BS];
    logic [DW-1:0] rdata = '0;
    int            n_chk = 0;
    int            n_pass = 0;
    int            lat;
    bit            saw_scan;

    pad_check #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BLOCK_SIZE(BS)) dut (
        .clk(clk), .rst(rst), .start(start),
        .memAddrLine(memAddrLine), .memDataLine(memDataLine),
        .dataLen(dataLen), .finish(finish), .error(error), .errCode(errCode)
    );

    always #5 clk = ~clk;

    // One-cycle read latency memory.
    assign memDataLine = rdata;
    always @(posedge clk) rdata <= mem[memAddrLine[5:0]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic load_good(input int len);
        for (int i = 0; i < BS - 1; i++) mem[i] = '0;
        if (len < BS - 1) mem[len] = 16'h0080;
        mem[BS-1] = 16'(len << 3);
    endtask

    // lat = rising edges after the edge that sampled start, until finish is seen.
    task automatic run(output int l, output bit scan);
        l = -1;
        scan = 1'b0;
        start = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk); #1;
            if (finish) begin
                l = k - 1;
                break;
            end
            if (memAddrLine !== 10'd63) scan = 1'b1;
        end
        chk("finish_seen", finish, 1);
    endtask

    task automatic stop_run();
        start = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0;
        for (int i = 0; i < BS; i++) mem[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_finish", finish, 0);
        chk("rst_error", error, 0);
        chk("rst_errCode", errCode, 0);
        chk("rst_dataLen", dataLen, 0);
        chk("rst_addr_z", (memAddrLine === 10'bz), 1);
        rst = 1'b1;
        @(posedge clk); #1;

        // len=5 good block
        load_good(5);
        run(lat, saw_scan);
        chk("len5_dataLen", dataLen, 5);
        chk("len5_error", error, 0);
        chk("len5_errCode", errCode, 0);
`ifdef PAD_FILL_CHECK_EN
        chk("len5_latency", lat, 61);
`else
        chk("len5_latency", lat, 5);
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("hold_finish", finish, 1);
        chk("hold_dataLen", dataLen, 5);
        stop_run();
        chk("release_finish", finish, 0);
        chk("release_addr_z", (memAddrLine === 10'bz), 1);

        // len=63: no marker/fill, no SCAN reads
        load_good(63);
        mem[10] = 16'h1234;
        run(lat, saw_scan);
        chk("len63_dataLen", dataLen, 63);
        chk("len63_error", error, 0);
        chk("len63_no_scan", saw_scan, 0);
        stop_run();

        // low bits set in length word
        load_good(5);
        mem[63] = 16'h0029;
        run(lat, saw_scan);
        chk("lowbits_error", error, 1);
        chk("lowbits_code", errCode, 1);
        chk("lowbits_dataLen", dataLen, 0);
        stop_run();

        // len=64 too large
        mem[63] = 16'h0200;
        run(lat, saw_scan);
        chk("len64_error", error, 1);
        chk("len64_code", errCode, 1);
        stop_run();

        // bad marker
        load_good(5);
        mem[5] = 16'h0000;
        run(lat, saw_scan);
        chk("marker_error", error, 1);
        chk("marker_code", errCode, 2);
        chk("marker_dataLen", dataLen, 0);
        stop_run();

        // nonzero fill byte
        load_good(5);
        mem[40] = 16'h0001;
        run(lat, saw_scan);
`ifdef PAD_FILL_CHECK_EN
        chk("fill_error", error, 1);
        chk("fill_code", errCode, 3);
        chk("fill_dataLen", dataLen, 0);
`else
        chk("fill_error", error, 0);
        chk("fill_code", errCode, 0);
        chk("fill_dataLen", dataLen, 5);
`endif
        stop_run();

        // len=62, marker upper bits set (ignored)
        load_good(62);
        mem[62] = 16'h7F80;
        run(lat, saw_scan);
        chk("len62_error", error, 0);
        chk("len62_dataLen", dataLen, 62);
`ifdef PAD_FILL_CHECK_EN
        chk("len62_latency", lat, 4);
`else
        chk("len62_latency", lat, 5);
`endif
        stop_run();

        // abort mid-SCAN, then restart
        load_good(5);
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_running", finish, 0);
        start = 1'b0;
        @(posedge clk); #1;
        chk("abort_finish", finish, 0);
        chk("abort_addr_z", (memAddrLine === 10'bz), 1);
        @(posedge clk); #1;
        run(lat, saw_scan);
        chk("restart_dataLen", dataLen, 5);
        chk("restart_error", error, 0);
        stop_run();

        // async reset mid-SCAN
        load_good(5);
        mem[5] = 16'h0000;
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("arst_addr_z", (memAddrLine === 10'bz), 1);
        chk("arst_finish", finish, 0);
        chk("arst_error", error, 0);
        chk("arst_errCode", errCode, 0);
        chk("arst_dataLen", dataLen, 0);
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("post_arst_finish", finish, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
